// File: rtl/gfx_dbuf_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gfx_dbuf_swap_ctrl
// Brief    : Double-buffer swap controller for the dual-SRAM graphics path.
//            Tracks in-flight draw writes, accepts swap requests, drains,
//            commits the display/draw swap on vertical blank and optionally
//            sequences a full-frame clear of the new draw buffer.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_dbuf_swap_ctrl #(
    parameter int FB_WIDTH        = 640,
    parameter int FB_HEIGHT       = 480,
    parameter int PIXEL_BITS      = 12,
    parameter int ADDR_BITS       = 20,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // Swap request from the renderer
    input  logic                  i_swap_req_valid,
    output logic                  o_swap_req_ready,
    input  logic                  i_swap_req_clear,
    input  logic [PIXEL_BITS-1:0] i_clear_color,
    // Draw write tracking
    input  logic                  i_wr_issue,
    input  logic                  i_wr_done,
    // Vertical blank pulse (already in clk domain)
    input  logic                  i_vblank_start,
    // Buffer selection and draw permission
    output logic                  o_disp_sel,
    output logic                  o_draw_gate,
    // Clear write stream
    output logic                  o_clr_valid,
    input  logic                  i_clr_ready,
    output logic [ADDR_BITS-1:0]  o_clr_addr,
    output logic [PIXEL_BITS-1:0] o_clr_color,
    // Status
    output logic                  o_swap_done,
    output logic [15:0]           o_frame_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                   c_OUTST_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int                   c_FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(c_FB_PIXELS - 1);
    localparam logic [c_OUTST_W-1:0] c_OUTST_MAX = c_OUTST_W'(MAX_OUTSTANDING);
    localparam logic [c_OUTST_W-1:0] c_OUTST_ONE = c_OUTST_W'(1);
    localparam logic [ADDR_BITS-1:0] c_ADDR_ONE  = ADDR_BITS'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_VWAIT = 3'd2,
        ST_SWAP  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [c_OUTST_W-1:0]    r_outst;
    logic                    r_disp_sel;
    logic [15:0]             r_frame_count;
    logic                    r_clr_pending;
    logic [PIXEL_BITS-1:0]   r_clr_color;
    logic [ADDR_BITS-1:0]    r_clr_addr;
    logic                    r_clr_valid;
    logic                    r_swap_done;

    logic                    w_req_hs;
    logic                    w_clr_fire;
    logic                    w_clr_last;
    logic                    w_in_idle;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_req_hs   = w_in_idle && i_swap_req_valid;
    assign w_clr_fire = r_clr_valid && i_clr_ready;
    assign w_clr_last = (r_clr_addr == c_LAST_ADDR);

    // ------------------------------------------------------------------------
    // Outstanding draw-write counter; saturates at both ends so a stray
    // completion or an over-issue never wraps the count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outst <= '0;
        end else begin
            case ({i_wr_issue, i_wr_done})
                2'b10: begin
                    if (r_outst != c_OUTST_MAX) begin
                        r_outst <= r_outst + c_OUTST_ONE;
                    end
                end
                2'b01: begin
                    if (r_outst != '0) begin
                        r_outst <= r_outst - c_OUTST_ONE;
                    end
                end
                default: begin
                    r_outst <= r_outst;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state decode. Vertical blank is only looked at in VWAIT, so a pulse
    // during IDLE (including the handshake cycle) or DRAIN has no effect.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_swap_req_valid) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_outst == '0) begin
                    w_state_nxt = ST_VWAIT;
                end
            end
            ST_VWAIT: begin
                if (i_vblank_start) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_nxt = r_clr_pending ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                if (w_clr_fire && w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture, buffer swap, clear address sequencing and done pulse.
    // clr_valid is raised in SWAP so it is already high on the first CLEAR
    // cycle and stays high until the last address is accepted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_sel    <= 1'b0;
            r_frame_count <= 16'd0;
            r_clr_pending <= 1'b0;
            r_clr_color   <= '0;
            r_clr_addr    <= '0;
            r_clr_valid   <= 1'b0;
            r_swap_done   <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_clr_pending <= i_swap_req_clear;
                        r_clr_color   <= i_clear_color;
                    end
                end
                ST_SWAP: begin
                    r_disp_sel    <= ~r_disp_sel;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_clr_addr    <= '0;
                    if (r_clr_pending) begin
                        r_clr_valid <= 1'b1;
                    end else begin
                        r_swap_done <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_fire) begin
                        if (w_clr_last) begin
                            r_clr_valid   <= 1'b0;
                            r_clr_pending <= 1'b0;
                            r_swap_done   <= 1'b1;
                        end else begin
                            r_clr_addr <= r_clr_addr + c_ADDR_ONE;
                        end
                    end
                end
                default: begin
                    r_clr_valid <= r_clr_valid;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: ready and draw gate decode registered state only.
    // ------------------------------------------------------------------------
    assign o_swap_req_ready = w_in_idle;
    assign o_draw_gate      = w_in_idle && (r_outst < c_OUTST_MAX);
    assign o_disp_sel       = r_disp_sel;
    assign o_frame_count    = r_frame_count;
    assign o_clr_valid      = r_clr_valid;
    assign o_clr_addr       = r_clr_addr;
    assign o_clr_color      = r_clr_color;
    assign o_swap_done      = r_swap_done;

endmodule
`default_nettype wire
